// File: rtl/f_stage_pkg.sv
// Shared fetch-stage constants: next-PC select encodings (also used by the
// D-stage controller), default reset PC and the bubble instruction word.
package f_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NPCOP_W   = 2;
    localparam int unsigned IMM16_W   = 16;
    localparam int unsigned INDEX26_W = 26;
    localparam int unsigned REG_W     = 5;

    localparam logic [NPCOP_W-1:0] NPC_PC4 = 2'b00;
    localparam logic [NPCOP_W-1:0] NPC_BR  = 2'b01;
    localparam logic [NPCOP_W-1:0] NPC_J   = 2'b10;
    localparam logic [NPCOP_W-1:0] NPC_JR  = 2'b11;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/f_stage_npc.sv
// Next-PC generator (purely combinational).
// Ports:
//   f_pc_i      current fetch PC
//   d_pc_i      PC of the instruction in decode
//   d_imm16_i   branch offset (words, signed)
//   d_index26_i jump target index
//   d_regdata_i forwarded rs value for jr
//   eff_op_i    effective next-PC select (already masked by D valid)
//   npc_o       next fetch PC, modulo 2^32
module npc_gen
    import f_stage_pkg::*;
(
    input  logic [XLEN-1:0]      f_pc_i,
    input  logic [XLEN-1:0]      d_pc_i,
    input  logic [IMM16_W-1:0]   d_imm16_i,
    input  logic [INDEX26_W-1:0] d_index26_i,
    input  logic [XLEN-1:0]      d_regdata_i,
    input  logic [NPCOP_W-1:0]   eff_op_i,
    output logic [XLEN-1:0]      npc_o
);

    logic [XLEN-1:0] br_off;

    // Sign-extended word offset converted to a byte offset.
    assign br_off = {{14{d_imm16_i[IMM16_W-1]}}, d_imm16_i, 2'b00};

    always_comb begin
        npc_o = f_pc_i + 32'd4;
        unique case (eff_op_i)
            NPC_PC4: npc_o = f_pc_i + 32'd4;
            NPC_BR:  npc_o = d_pc_i + 32'd4 + br_off;
            NPC_J:   npc_o = {d_pc_i[31:28], d_index26_i, 2'b00};
            NPC_JR:  npc_o = d_regdata_i;
            default: npc_o = f_pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/f_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the F/D
// pipeline register, with decoded field taps for D-stage logic.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_inst_addr   fetch address (the PC register)
//   i_inst_rdata  instruction word returned for i_inst_addr
//   stall         freeze PC and F/D register
//   D_Flush       load a bubble into F/D
//   D_NPCOp       next-PC select from D-stage controller
//   D_RegData     forwarded rs value for jr
//   D_Instr/D_PC/D_Valid  F/D register contents
//   D_Imm16/D_Index26/D_rs/D_rt/D_rd  fields of D_Instr
module f_stage
    import f_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [XLEN-1:0]      i_inst_addr,
    input  logic [XLEN-1:0]      i_inst_rdata,
    input  logic                 stall,
    input  logic                 D_Flush,
    input  logic [NPCOP_W-1:0]   D_NPCOp,
    input  logic [XLEN-1:0]      D_RegData,
    output logic [XLEN-1:0]      D_Instr,
    output logic [XLEN-1:0]      D_PC,
    output logic                 D_Valid,
    output logic [IMM16_W-1:0]   D_Imm16,
    output logic [INDEX26_W-1:0] D_Index26,
    output logic [REG_W-1:0]     D_rs,
    output logic [REG_W-1:0]     D_rt,
    output logic [REG_W-1:0]     D_rd
);

    logic [XLEN-1:0]    f_pc_q,    f_pc_d;
    logic [XLEN-1:0]    d_instr_q, d_instr_d;
    logic [XLEN-1:0]    d_pc_q,    d_pc_d;
    logic               d_valid_q, d_valid_d;
    logic [NPCOP_W-1:0] eff_op;
    logic [XLEN-1:0]    npc;

    // A bubble in decode must never redirect fetch.
    assign eff_op = d_valid_q ? D_NPCOp : NPC_PC4;

    npc_gen u_npc (
        .f_pc_i      (f_pc_q),
        .d_pc_i      (d_pc_q),
        .d_imm16_i   (d_instr_q[15:0]),
        .d_index26_i (d_instr_q[25:0]),
        .d_regdata_i (D_RegData),
        .eff_op_i    (eff_op),
        .npc_o       (npc)
    );

    // Next-state: stall holds everything, flush advances PC but loads a bubble.
    always_comb begin
        f_pc_d    = f_pc_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_valid_d = d_valid_q;
        if (!stall) begin
            f_pc_d = npc;
            d_pc_d = f_pc_q;
            if (D_Flush) begin
                d_instr_d = NOP_INSTR;
                d_valid_d = 1'b0;
            end else begin
                d_instr_d = i_inst_rdata;
                d_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q    <= RESET_PC;
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= '0;
            d_valid_q <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign i_inst_addr = f_pc_q;
    assign D_Instr     = d_instr_q;
    assign D_PC        = d_pc_q;
    assign D_Valid     = d_valid_q;
    assign D_Imm16     = d_instr_q[15:0];
    assign D_Index26   = d_instr_q[25:0];
    assign D_rs        = d_instr_q[25:21];
    assign D_rt        = d_instr_q[20:16];
    assign D_rd        = d_instr_q[15:11];

endmodule

// File: tb/tb_f_stage.sv
// Directed bench for f_stage: a vector table walks the pipeline through
// branch, jump, jr-under-stall and flush cases; hand sequences cover reset
// mid-stall and PC wrap-around on a second instance.
module tb_f_stage;
    import f_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, D_Flush;
    logic [1:0]  D_NPCOp;
    logic [31:0] D_RegData, i_inst_addr, i_inst_rdata, D_Instr, D_PC;
    logic        D_Valid;
    logic [15:0] D_Imm16;
    logic [25:0] D_Index26;
    logic [4:0]  D_rs, D_rt, D_rd;

    logic        w_reset;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;
    logic        w_valid;
    logic [15:0] w_imm;
    logic [25:0] w_idx;
    logic [4:0]  w_rs, w_rt, w_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: addr ^ pattern, plus a branch and a jump word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_3008: return 32'h1000_FFFE;
            32'h0000_3010: return 32'h0800_0C10;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);
    assign w_rdata      = mem_word(w_addr);

    f_stage dut (
        .clk(clk), .reset(reset), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .stall(stall), .D_Flush(D_Flush), .D_NPCOp(D_NPCOp), .D_RegData(D_RegData),
        .D_Instr(D_Instr), .D_PC(D_PC), .D_Valid(D_Valid), .D_Imm16(D_Imm16),
        .D_Index26(D_Index26), .D_rs(D_rs), .D_rt(D_rt), .D_rd(D_rd)
    );

    f_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(w_reset), .i_inst_addr(w_addr), .i_inst_rdata(w_rdata),
        .stall(1'b0), .D_Flush(1'b0), .D_NPCOp(2'b00), .D_RegData(32'h0),
        .D_Instr(w_instr), .D_PC(w_pc), .D_Valid(w_valid), .D_Imm16(w_imm),
        .D_Index26(w_idx), .D_rs(w_rs), .D_rt(w_rt), .D_rd(w_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  op;
        logic [31:0] regdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_dpc;
        logic [31:0] exp_di;
        logic        exp_v;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] fe;
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3004, 32'h3000, 32'hA5A5_3000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3008, 32'h3004, 32'hA5A5_3004, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h300C, 32'h3008, 32'h1000_FFFE, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0,    32'h3004, 32'h300C, 32'hA5A5_300C, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3008, 32'h3004, 32'hA5A5_3004, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h300C, 32'h3008, 32'h1000_FFFE, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3010, 32'h300C, 32'hA5A5_300C, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3014, 32'h3010, 32'h0800_0C10, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0,    32'h3040, 32'h3014, 32'hA5A5_3014, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h3044, 32'h3040, 32'hA5A5_3040, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h3048, 32'h3044, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h0,    32'h304C, 32'h3048, 32'hA5A5_3048, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'b11, 32'h1111, 32'h304C, 32'h3048, 32'hA5A5_3048, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 32'h2222, 32'h304C, 32'h3048, 32'hA5A5_3048, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'b11, 32'h3100, 32'h3100, 32'h304C, 32'hA5A5_304C, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'b11, 32'h3020, 32'h3020, 32'h3100, 32'hA5A5_3100, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 2'b00, 32'h0,    32'h3020, 32'h3100, 32'hA5A5_3100, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h3024, 32'h3020, 32'h0,         1'b0};
        vecs[18] = '{1'b0, 1'b0, 2'b01, 32'h0,    32'h3028, 32'h3024, 32'hA5A5_3024, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 2'b11, 32'h3040, 32'h3040, 32'h3028, 32'hA5A5_3028, 1'b1};

        reset = 1'b1; w_reset = 1'b1;
        stall = 1'b0; D_Flush = 1'b0; D_NPCOp = 2'b00; D_RegData = 32'h0;
        step();
        check("rst_addr",  i_inst_addr, 32'h3000);
        check("rst_valid", 32'(D_Valid), 32'h0);
        check("rst_instr", D_Instr, 32'h0);
        check("rst_dpc",   D_PC, 32'h0);
        check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);

        // Wrap-around instance: one PC+4 edge from FFFF_FFFC.
        w_reset = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < 20; i++) begin
            stall     = vecs[i].stall;
            D_Flush   = vecs[i].flush;
            D_NPCOp   = vecs[i].op;
            D_RegData = vecs[i].regdata;
            step();
            if (i == 0) begin
                check("wrap_addr",  w_addr, 32'h0);
                check("wrap_dpc",   w_pc, 32'hFFFF_FFFC);
                check("wrap_instr", w_instr, 32'h5A5A_FFFC);
                check("imm16_first", 32'(D_Imm16), 32'h3000);
            end
            check($sformatf("v%0d_addr", i),  i_inst_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_dpc", i),   D_PC, vecs[i].exp_dpc);
            check($sformatf("v%0d_instr", i), D_Instr, vecs[i].exp_di);
            check($sformatf("v%0d_valid", i), 32'(D_Valid), 32'(vecs[i].exp_v));
            fe = vecs[i].exp_di;
            check($sformatf("v%0d_fields", i),
                  {D_rs, D_rt, D_rd, D_Imm16[10:0], 6'(D_Index26[25:20])},
                  {fe[25:21], fe[20:16], fe[15:11], fe[10:0], fe[25:20]});
        end

        // Reset asserted mid-stall and mid-flush wins over both.
        stall = 1'b1; D_Flush = 1'b1; D_NPCOp = 2'b11; D_RegData = 32'h5555;
        reset = 1'b1;
        step();
        check("rst2_addr",  i_inst_addr, 32'h3000);
        check("rst2_instr", D_Instr, 32'h0);
        check("rst2_dpc",   D_PC, 32'h0);
        check("rst2_valid", 32'(D_Valid), 32'h0);
        check("rst2_fields", {D_rs, D_rt, D_rd, D_Imm16}, 31'h0);

        // First fetch after reset comes from RESET_PC.
        reset = 1'b0; stall = 1'b0; D_Flush = 1'b0; D_NPCOp = 2'b00;
        step();
        check("post_rst_dpc",   D_PC, 32'h3000);
        check("post_rst_instr", D_Instr, 32'hA5A5_3000);
        check("post_rst_addr",  i_inst_addr, 32'h3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_stage.md
Name: f_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode-stage immediate extender.
- Holds the PC register and computes the next PC from D-stage branch/jump decisions; delay-slot semantics apply.
- Presents the fetch address to the external instruction memory.
- Captures instruction and PC into the F/D pipeline register, then exposes the decoded fields, including D_Imm16, to D-stage logic.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_inst_addr  out  32  fetch address (= F_PC) to instruction memory
- i_inst_rdata  in  32  instruction word at i_inst_addr, combinational return
- stall  in  1  from hazard unit; freeze PC and F/D register
- D_Flush  in  1  replace the F/D contents with a bubble this cycle
- D_NPCOp  in  2  next-PC select from D-stage controller: 00 PC+4, 01 branch-taken, 10 j/jal, 11 jr
- D_RegData  in  32  forwarded rs value for jr
- D_Instr  out  32  F/D instruction
- D_PC  out  32  F/D PC
- D_Valid  out  1  F/D holds a real instruction (0 = bubble)
- D_Imm16  out  16  D_Instr[15:0], feeds the extender
- D_Index26  out  26  D_Instr[25:0]
- D_rs, D_rt, D_rd  out  5 each  D_Instr[25:21], [20:16], [15:11]

Behaviour:
- Reset (synchronous, highest priority):
  - F_PC <= RESET_PC.
  - D_Instr <= 0, D_PC <= 0, D_Valid <= 0.
  - Field outputs follow D_Instr, so they are also 0.
- i_inst_addr = F_PC combinationally.
- Fetch latency is 1: the word returned for F_PC appears on D_Instr after the next rising edge (when not stalled).
- Effective op: effOp = D_Valid ? D_NPCOp : 00. Bubbles never redirect fetch.
- NPC, all arithmetic modulo 2^32:
  - 00: F_PC + 4.
  - 01: D_PC + 4 + (sign_extend(D_Imm16) << 2).
  - 10: {D_PC[31:28], D_Index26, 2'b00}.
  - 11: D_RegData, passed unchanged with no alignment check or trap.
- Delay slot: when D holds a branch/jump, F_PC is already its delay slot. The delay slot is still latched into F/D normally; no implicit flush.
- Per-edge priority is reset > stall > flush > normal.
  - stall = 1: F_PC, D_Instr, D_PC and D_Valid all hold. D_NPCOp is ignored for this cycle and re-evaluated when the stall drops, so a stalled jr waiting on forwarding is correct.
  - D_Flush = 1, stall = 0: F_PC <= NPC; D_Instr <= 0; D_Valid <= 0; D_PC <= F_PC, keeping the PC trace continuous.
  - Normal: F_PC <= NPC; D_Instr <= i_inst_rdata; D_PC <= F_PC; D_Valid <= 1.
- Wrap-around: F_PC = FFFF_FFFC with op 00 gives 0000_0000, with no flag.
- Reset mid-stall or mid-flush: reset wins. The first post-reset fetch address is RESET_PC.

Decomposition:
- Shared package:
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR 2-bit constants, shared with the D-stage controller.
  - RESET_PC default.
  - NOP_INSTR = 32'h0.
- One natural sub-module: npc_gen, purely combinational, with inputs F_PC, D_PC, D_Imm16, D_Index26, D_RegData, effOp and output NPC.
- PC register and F/D register stay in f_stage.

Test Plan:
1. Reset then free run, memory returning instr = addr ^ 32'hA5A5_0000:
   - During reset, i_inst_addr = 0x3000, D_Valid = 0, D_Instr = 0.
   - Cycle 1: addr 0x3004, D_PC = 0x3000, D_Instr = 0xA5A5_3000, D_Imm16 = 0x3000, D_Valid = 1.
2. Taken branch: D_PC = 0x3008, D_Imm16 = 0xFFFE, D_NPCOp = 01, F_PC = 0x300C.
   - Next edge: F_PC = 0x3004.
   - D_PC = 0x300C (delay slot kept, D_Valid = 1).
3. Jump: D_PC = 0x3010, D_Index26 = 0x0000C10, op = 10 -> F_PC = 0x0000_3040.
   - Same with D_Valid = 0 -> F_PC = old F_PC + 4.
4. jr under stall: stall = 1 for 2 cycles with op = 11 and D_RegData changing.
   - All state frozen during the stall.
   - stall = 0 with D_RegData = 0x3100 -> F_PC = 0x3100.
5. Flush/stall mix:
   - stall = 1 & D_Flush = 1 -> full hold.
   - D_Flush = 1 alone at F_PC = 0x3020 -> D_Instr = 0, D_Valid = 0, D_PC = 0x3020, F_PC = 0x3024.
6. Boundaries:
   - RESET_PC = 32'hFFFF_FFFC, op 00 -> F_PC = 0 after one edge.
   - Assert reset while F_PC = 0x3040 and stall = 1 -> F_PC = RESET_PC, D outputs 0 on the next edge.
